capture_trig_ctrl: RTL and testbench

- Sequencing controller for the AXI bus-capture datapath.
- Takes the registered 378-bit bus snapshot and decides which cycles are stored into a circular trace RAM.
- Detects a masked-match trigger, then counts a programmable number of post-trigger samples before freezing.
- Sits between the capture register and a dual-port trace BRAM whose read side belongs to the debug readout logic.

---
 rtl/capture_pkg.sv | 18 +
 rtl/capture_trig_match.sv | 23 ++
 rtl/capture_trig_ctrl.sv | 172 +++++++++++++++++
 tb/tb_capture_trig_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// -----------------------------------------------------------------------------
// capture_pkg
// Shared definitions for the AXI bus-capture datapath.
//   CAPTURE_W   : width of one registered bus snapshot
//   cap_state_e : sequencing state of the capture/trigger controller
// -----------------------------------------------------------------------------
package capture_pkg;

  localparam int CAPTURE_W = 378;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/capture_trig_match.sv
// -----------------------------------------------------------------------------
// capture_trig_match
// Purely combinational masked compare of one capture sample against a
// trigger pattern. Only bits set in the mask take part in the compare, so
// an all-zero mask always matches.
// Ports:
//   capture_i [W] : sample under test
//   mask_i    [W] : compare mask (1 = bit participates)
//   value_i   [W] : compare value
//   match_o       : 1 when the masked sample equals the masked value
// -----------------------------------------------------------------------------
module capture_trig_match #(
  parameter int W = capture_pkg::CAPTURE_W
) (
  input  logic [W-1:0] capture_i,
  input  logic [W-1:0] mask_i,
  input  logic [W-1:0] value_i,
  output logic         match_o
);

  assign match_o = ((capture_i & mask_i) == (value_i & mask_i));

endmodule

// File: rtl/capture_trig_ctrl.sv
// -----------------------------------------------------------------------------
// capture_trig_ctrl
// Sequencing controller for the AXI bus-capture datapath. Decides which
// registered bus snapshots are written into a circular trace RAM, detects
// a masked-match trigger and then stores a programmable number of further
// qualified samples before freezing.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   capture_i             : registered bus snapshot, new every cycle
//   qual_i                : sample is stored only when high
//   trig_mask_i/value_i   : trigger compare mask and value
//   post_count_i          : samples to store after the trigger (latched on arm)
//   arm_i, abort_i        : single-cycle control pulses (abort wins)
//   wr_en_o/addr_o/data_o : trace RAM write port, one cycle after the sample
//   trig_addr_o           : RAM address holding the trigger sample
//   wrapped_o             : ring has wrapped, every entry is valid
//   armed_o, done_o       : status (ARMED/POST, DONE)
// Software readout: oldest entry is the final pointer when wrapped_o is set,
// otherwise entry 0; newest entry is the final pointer minus one.
// -----------------------------------------------------------------------------
module capture_trig_ctrl #(
  parameter int CAPTURE_W = capture_pkg::CAPTURE_W,
  parameter int DEPTH     = 1024,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CAPTURE_W-1:0] capture_i,
  input  logic                 qual_i,
  input  logic [CAPTURE_W-1:0] trig_mask_i,
  input  logic [CAPTURE_W-1:0] trig_value_i,
  input  logic [AW-1:0]        post_count_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  output logic                 wr_en_o,
  output logic [AW-1:0]        wr_addr_o,
  output logic [CAPTURE_W-1:0] wr_data_o,
  output logic [AW-1:0]        trig_addr_o,
  output logic                 wrapped_o,
  output logic                 armed_o,
  output logic                 done_o
);

  import capture_pkg::*;

  cap_state_e           state_q;
  cap_state_e           state_d;

  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        post_cnt_q;
  logic [AW-1:0]        trig_addr_q;
  logic [AW-1:0]        wr_addr_q;
  logic [CAPTURE_W-1:0] wr_data_q;
  logic                 wr_en_q;
  logic                 wrapped_q;

  logic                 trig_match;
  logic                 capturing;
  logic                 store;
  logic                 trig_hit;
  logic                 start;
  logic                 last_post;

  capture_trig_match #(
    .W (CAPTURE_W)
  ) u_trig_match (
    .capture_i (capture_i),
    .mask_i    (trig_mask_i),
    .value_i   (trig_value_i),
    .match_o   (trig_match)
  );

  // Abort suppresses the store of its own cycle so nothing new is issued
  // once the controller has been told to stop.
  assign capturing = (state_q == ARMED) || (state_q == POST);
  assign store     = capturing && qual_i && !abort_i;
  assign trig_hit  = store && (state_q == ARMED) && trig_match;
  assign start     = arm_i && !abort_i && ((state_q == IDLE) || (state_q == DONE));
  assign last_post = (post_cnt_q == AW'(1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The post counter is never zero while in POST because
  // a zero count goes straight from the trigger to DONE.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm_i) state_d = ARMED;
        end
        ARMED: begin
          if (qual_i && trig_match) begin
            state_d = (post_cnt_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (qual_i && last_post) state_d = DONE;
        end
        DONE: begin
          if (arm_i) state_d = ARMED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    armed_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ARMED, POST: armed_o = 1'b1;
      DONE:        done_o  = 1'b1;
      default:     ;
    endcase
  end

  // Write path and bookkeeping. A store registers the RAM write for the
  // next cycle; a write already registered when reset or abort arrives is
  // simply presented as usual during that cycle. start and store are
  // mutually exclusive since they need different states.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_ptr_q    <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      wr_en_q <= store;
      if (store) begin
        wr_addr_q <= wr_ptr_q;
        wr_data_q <= capture_i;
        wr_ptr_q  <= wr_ptr_q + AW'(1);
        if (wr_ptr_q == AW'(DEPTH - 1)) begin
          wrapped_q <= 1'b1;
        end
        if (trig_hit) begin
          trig_addr_q <= wr_ptr_q;
        end
        if (state_q == POST) begin
          post_cnt_q <= post_cnt_q - AW'(1);
        end
      end
      if (start) begin
        wr_ptr_q    <= '0;
        wrapped_q   <= 1'b0;
        trig_addr_q <= '0;
        post_cnt_q  <= post_count_i;
      end
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign trig_addr_o = trig_addr_q;
  assign wrapped_o   = wrapped_q;

endmodule

// File: tb/tb_capture_trig_ctrl.sv
// -----------------------------------------------------------------------------
// tb_capture_trig_ctrl
// Directed bench for capture_trig_ctrl with DEPTH=16. A sample-count model
// predicts every output each cycle; literal checks pin key scenario results.
// -----------------------------------------------------------------------------
module tb_capture_trig_ctrl;

  localparam int W     = capture_pkg::CAPTURE_W;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [W-1:0]  capture_i;
  logic          qual_i;
  logic [W-1:0]  trig_mask_i;
  logic [W-1:0]  trig_value_i;
  logic [AW-1:0] post_count_i;
  logic          arm_i;
  logic          abort_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [W-1:0]  wr_data_o;
  logic [AW-1:0] trig_addr_o;
  logic          wrapped_o;
  logic          armed_o;
  logic          done_o;

  always #5 clk = ~clk;

  capture_trig_ctrl #(
    .CAPTURE_W (W),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .capture_i    (capture_i),
    .qual_i       (qual_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
    .post_count_i (post_count_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .trig_addr_o  (trig_addr_o),
    .wrapped_o    (wrapped_o),
    .armed_o      (armed_o),
    .done_o       (done_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int obs[$];

  // Model: counts samples stored since arm, derives addresses arithmetically.
  bit            m_valid      = 1'b0;
  bit            m_active     = 1'b0;
  bit            m_done       = 1'b0;
  bit            m_trig       = 1'b0;
  bit            m_trig_known = 1'b0;
  int            m_stored     = 0;
  int            m_rem        = 0;
  int            m_latched    = 0;
  logic          e_wr_en      = 1'b0;
  logic [AW-1:0] e_addr       = '0;
  logic [W-1:0]  e_data       = '0;
  logic [AW-1:0] e_trig       = '0;
  logic          e_wrapped    = 1'b0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic modelUpdate();
    if (rst_i) begin
      m_valid = 1'b1; m_active = 1'b0; m_done = 1'b0; m_trig = 1'b0;
      m_trig_known = 1'b1; m_stored = 0; m_rem = 0;
      e_wr_en = 1'b0; e_addr = '0; e_data = '0; e_trig = '0; e_wrapped = 1'b0;
    end else if (m_valid) begin
      e_wr_en = 1'b0;
      if (abort_i) begin
        m_active = 1'b0;
        m_done   = 1'b0;
      end else if (m_active && qual_i) begin
        e_wr_en = 1'b1;
        e_addr  = AW'(m_stored % DEPTH);
        e_data  = capture_i;
        m_stored++;
        if (m_stored >= DEPTH) e_wrapped = 1'b1;
        if (!m_trig) begin
          if ((capture_i & trig_mask_i) == (trig_value_i & trig_mask_i)) begin
            m_trig = 1'b1; m_trig_known = 1'b1;
            e_trig = AW'((m_stored - 1) % DEPTH);
            m_rem  = m_latched;
            if (m_rem == 0) begin m_active = 1'b0; m_done = 1'b1; end
          end
        end else begin
          m_rem--;
          if (m_rem == 0) begin m_active = 1'b0; m_done = 1'b1; end
        end
      end else if (arm_i && !m_active) begin
        m_active = 1'b1; m_done = 1'b0; m_trig = 1'b0; m_trig_known = 1'b0;
        m_stored = 0; m_latched = int'(post_count_i); e_wrapped = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("wr_en", W'(wr_en_o), W'(e_wr_en));
      checkOutput("wr_addr", W'(wr_addr_o), W'(e_addr));
      checkOutput("wr_data", wr_data_o, e_data);
      checkOutput("wrapped", W'(wrapped_o), W'(e_wrapped));
      checkOutput("armed", W'(armed_o), W'(m_active));
      checkOutput("done", W'(done_o), W'(m_done));
      if (m_trig_known) checkOutput("trig_addr", W'(trig_addr_o), W'(e_trig));
      if (wr_en_o === 1'b1) obs.push_back(int'(wr_addr_o));
    end
  end

  function automatic logic [W-1:0] rndCap();
    logic [W-1:0] r = '0;
    for (int i = 0; i < 12; i++) r = {r[W-33:0], $urandom()};
    if (r[7:0] == 8'h2A) r[7:0] = 8'h2B;
    return r;
  endfunction

  function automatic logic [W-1:0] matchCap();
    logic [W-1:0] r = rndCap();
    r[7:0] = 8'h2A;
    return r;
  endfunction

  task automatic applyStimulus(input logic arm, input logic abort, input logic qual,
                               input logic rst, input logic [W-1:0] cap);
    arm_i = arm; abort_i = abort; qual_i = qual; rst_i = rst; capture_i = cap;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    #1;
  endtask

  task automatic runQual(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, rndCap());
  endtask

  task automatic setTrigByte(input logic on);
    trig_mask_i  = '0;
    trig_value_i = '0;
    if (on) begin
      trig_mask_i[7:0]  = 8'hFF;
      trig_value_i[7:0] = 8'h2A;
    end
  endtask

  initial begin
    rst_i = 1'b1; arm_i = 1'b0; abort_i = 1'b0; qual_i = 1'b0;
    capture_i = '0; trig_mask_i = '0; trig_value_i = '0; post_count_i = '0;

    // Reset
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checkOutput("rst_wr_en", W'(wr_en_o), W'(0));
    checkOutput("rst_armed", W'(armed_o), W'(0));
    checkOutput("rst_done", W'(done_o), W'(0));
    checkOutput("rst_trig_addr", W'(trig_addr_o), W'(0));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, rndCap());

    // Basic: mask 0, post 3
    setTrigByte(1'b0); post_count_i = 4'd3; obs.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, rndCap());
    runQual(6);
    checkOutput("basic_writes", W'(obs.size()), W'(4));
    for (int i = 0; i < obs.size(); i++) checkOutput($sformatf("basic_addr%0d", i), W'(obs[i]), W'(i));
    checkOutput("basic_trig", W'(trig_addr_o), W'(0));
    checkOutput("basic_done", W'(done_o), W'(1));
    checkOutput("basic_wrapped", W'(wrapped_o), W'(0));

    // Pre-trigger wrap: 20 misses, match at index 20, post 2
    setTrigByte(1'b1); post_count_i = 4'd2; obs.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, rndCap());
    runQual(20);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, matchCap());
    runQual(4);
    checkOutput("wrap_writes", W'(obs.size()), W'(23));
    checkOutput("wrap_trig", W'(trig_addr_o), W'(4));
    checkOutput("wrap_wrapped", W'(wrapped_o), W'(1));
    checkOutput("wrap_done", W'(done_o), W'(1));
    checkOutput("wrap_addr21", W'(obs[21]), W'(5));
    checkOutput("wrap_addr22", W'(obs[22]), W'(6));

    // Qualifier gating
    post_count_i = 4'd2; obs.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, rndCap());
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, matchCap());
    checkOutput("qual_still_armed", W'(armed_o), W'(1));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, rndCap());
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, matchCap());
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, rndCap());
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, matchCap());
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, rndCap());
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rndCap());
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, rndCap());
    checkOutput("qual_writes", W'(obs.size()), W'(4));
    checkOutput("qual_trig", W'(trig_addr_o), W'(1));
    checkOutput("qual_done", W'(done_o), W'(1));

    // post_count = 0
    setTrigByte(1'b0); post_count_i = 4'd0; obs.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, rndCap());
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, rndCap());
    checkOutput("p0_done_now", W'(done_o), W'(1));
    checkOutput("p0_wr_now", W'(wr_en_o), W'(1));
    runQual(3);
    checkOutput("p0_writes", W'(obs.size()), W'(1));

    // post_count = DEPTH-1
    post_count_i = 4'd15; obs.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, rndCap());
    runQual(20);
    checkOutput("p15_writes", W'(obs.size()), W'(16));
    checkOutput("p15_wrapped", W'(wrapped_o), W'(1));
    checkOutput("p15_trig", W'(trig_addr_o), W'(0));
    checkOutput("p15_last_addr", W'(obs[15]), W'(15));

    // Control races
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, rndCap());
    checkOutput("abort_done_clr", W'(done_o), W'(0));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, rndCap());
    checkOutput("arm_abort_idle", W'(armed_o), W'(0));
    setTrigByte(1'b1); post_count_i = 4'd3; obs.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, rndCap());
    runQual(3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, rndCap());
    runQual(1);
    checkOutput("rearm_no_reset", W'(obs[4]), W'(4));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, matchCap());
    runQual(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, rndCap());
    checkOutput("abort_post_armed", W'(armed_o), W'(0));
    checkOutput("abort_post_done", W'(done_o), W'(0));
    runQual(2);
    checkOutput("abort_writes", W'(obs.size()), W'(7));

    // Reset mid-POST then re-arm
    setTrigByte(1'b0); post_count_i = 4'd5; obs.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, rndCap());
    runQual(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, rndCap());
    checkOutput("rstm_wr_en", W'(wr_en_o), W'(0));
    checkOutput("rstm_wr_addr", W'(wr_addr_o), W'(0));
    checkOutput("rstm_wr_data", wr_data_o, W'(0));
    checkOutput("rstm_armed", W'(armed_o), W'(0));
    checkOutput("rstm_done", W'(done_o), W'(0));
    post_count_i = 4'd1; obs.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, rndCap());
    runQual(3);
    checkOutput("rearm_writes", W'(obs.size()), W'(2));
    checkOutput("rearm_addr0", W'(obs[0]), W'(0));
    checkOutput("rearm_addr1", W'(obs[1]), W'(1));
    checkOutput("rearm_done", W'(done_o), W'(1));

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
